// File: rtl/isr_cpl_join_pkg.sv
// Shared types and sizing for the ISR split-DMA completion joiner.
package lynxTypes;

   localparam int unsigned ISR_CPL_TAG_BITS = 10;
   localparam int unsigned ISR_CPL_DEPTH    = 16;

   // Completion tag as packed by the issuer: pid in the upper bits, dest below.
   typedef struct packed {
      logic [5:0] pid;
      logic [3:0] dest;
   } isr_cpl_t;

endpackage

// File: rtl/isr_tag_fifo.sv
// Synchronous register FIFO holding the tags of issued, not-yet-retired requests.
module isr_tag_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 10
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_do;
   logic          rd_do;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign wr_do   = wr_en & ~full;
   assign rd_do   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   // Storage array; contents need no reset since count gates every read.
   always_ff @(posedge aclk) begin
      if (wr_do) mem[wr_ptr] <= wr_data;
   end

   // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_do) wr_ptr <= wr_ptr + AW'(1);
         if (rd_do) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr_do) - CW'(rd_do);
      end
   end

endmodule

// File: rtl/isr_cpl_join.sv
// Joins host/card halves of split ISR DMA requests into one in-order completion.
module isr_cpl_join
   import lynxTypes::*;
#(
   parameter int unsigned DEPTH = ISR_CPL_DEPTH,
   parameter int unsigned TAG_W = ISR_CPL_TAG_BITS
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     issue_valid,
   output logic                     issue_ready,
   input  logic [TAG_W-1:0]         issue_tag,
   input  logic                     host_done,
   input  logic                     card_done,
   output logic                     cpl_valid,
   input  logic                     cpl_ready,
   output logic [TAG_W-1:0]         cpl_tag,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     err_overrun
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state;
   logic [CW-1:0]    host_cnt;
   logic [CW-1:0]    card_cnt;
   logic [CW-1:0]    host_eff;
   logic [CW-1:0]    card_eff;
   logic             host_ok;
   logic             card_ok;
   logic             head_rdy;
   logic             retire;
   logic             fifo_full;
   logic             fifo_empty;
   logic [TAG_W-1:0] head_tag;
   logic [CW-1:0]    fifo_count;

   isr_tag_fifo #(.DEPTH(DEPTH), .W(TAG_W)) u_fifo (
      .aclk    (aclk),
      .areset  (areset),
      .wr_en   (issue_valid),
      .wr_data (issue_tag),
      .rd_en   (retire),
      .rd_data (head_tag),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign issue_ready = ~fifo_full;
   assign outstanding = fifo_count;

   // Accept legal dones and decide retire; a done counts toward the head in its own cycle.
   always_comb begin
      host_ok  = host_done & (host_cnt < fifo_count);
      card_ok  = card_done & (card_cnt < fifo_count);
      host_eff = host_cnt + CW'(host_ok);
      card_eff = card_cnt + CW'(card_ok);
      head_rdy = ~fifo_empty & (host_eff != '0) & (card_eff != '0);
      retire   = head_rdy & ((state == IDLE) | cpl_ready);
   end

   // Join FSM, pending-half counters, sticky overrun and the registered completion.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state       <= IDLE;
         cpl_valid   <= 1'b0;
         cpl_tag     <= '0;
         host_cnt    <= '0;
         card_cnt    <= '0;
         err_overrun <= 1'b0;
      end else begin
         host_cnt <= host_eff - CW'(retire);
         card_cnt <= card_eff - CW'(retire);
         if ((host_done & ~host_ok) | (card_done & ~card_ok)) err_overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (retire) begin
                  state     <= HOLD;
                  cpl_valid <= 1'b1;
                  cpl_tag   <= head_tag;
               end
            end
            HOLD: begin
               if (cpl_ready) begin
                  if (retire) begin
                     cpl_tag <= head_tag;
                  end else begin
                     state     <= IDLE;
                     cpl_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               cpl_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_isr_cpl_join.sv
// Randomized and directed bench for isr_cpl_join against a queue-based reference model.
module tb_isr_cpl_join;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned TAG_W = 10;
   localparam int unsigned OW    = $clog2(DEPTH) + 1;

   logic             aclk = 1'b0;
   logic             areset;
   logic             issue_valid;
   logic             issue_ready;
   logic [TAG_W-1:0] issue_tag;
   logic             host_done;
   logic             card_done;
   logic             cpl_valid;
   logic             cpl_ready;
   logic [TAG_W-1:0] cpl_tag;
   logic [OW-1:0]    outstanding;
   logic             err_overrun;

   int n_chk = 0;
   int n_bad = 0;

   // Reference model state: issued tags in order, finished halves per side, output slot.
   logic [TAG_W-1:0] tq[$];
   int               m_h;
   int               m_c;
   bit               m_valid;
   logic [TAG_W-1:0] m_tag;
   bit               m_err;

   isr_cpl_join #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .aclk        (aclk),
      .areset      (areset),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_tag   (issue_tag),
      .host_done   (host_done),
      .card_done   (card_done),
      .cpl_valid   (cpl_valid),
      .cpl_ready   (cpl_ready),
      .cpl_tag     (cpl_tag),
      .outstanding (outstanding),
      .err_overrun (err_overrun)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", t, got, exp, $time);
      end
   endtask

   // One clock: advance the model on the edge, then compare all outputs just after it.
   task automatic step();
      int sz;
      @(posedge aclk);
      if (areset) begin
         tq.delete();
         m_h = 0; m_c = 0; m_valid = 0; m_tag = '0; m_err = 0;
      end else begin
         sz = tq.size();
         if (host_done) begin if (m_h < sz) m_h++; else m_err = 1; end
         if (card_done) begin if (m_c < sz) m_c++; else m_err = 1; end
         if (!m_valid || cpl_ready) begin
            if (sz > 0 && m_h > 0 && m_c > 0) begin
               m_tag = tq.pop_front();
               m_h--; m_c--;
               m_valid = 1;
            end else begin
               m_valid = 0;
            end
         end
         if (issue_valid && sz < DEPTH) tq.push_back(issue_tag);
      end
      #1;
      chk("m_rdy", 32'(issue_ready), 32'(tq.size() < DEPTH));
      chk("m_out", 32'(outstanding), 32'(tq.size()));
      chk("m_vld", 32'(cpl_valid), 32'(m_valid));
      if (m_valid) chk("m_tag", 32'(cpl_tag), 32'(m_tag));
      chk("m_err", 32'(err_overrun), 32'(m_err));
   endtask

   task automatic drv(input bit iv, input logic [TAG_W-1:0] t, input bit hd, input bit cd, input bit cr);
      issue_valid = iv; issue_tag = t; host_done = hd; card_done = cd; cpl_ready = cr;
      step();
   endtask

   task automatic do_reset();
      areset = 1'b1;
      drv(0, '0, 0, 0, 0);
      areset = 1'b0;
   endtask

   // Finish every outstanding request with legal dones and drain completions.
   task automatic drain();
      int k = 0;
      while ((tq.size() > 0 || m_valid) && k < 200) begin
         drv(0, '0, m_h < tq.size(), m_c < tq.size(), 1);
         k++;
      end
      chk("drain_out", 32'(outstanding), 32'(0));
      chk("drain_vld", 32'(cpl_valid), 32'(0));
   endtask

   initial begin
      areset = 1'b1;
      issue_valid = 0; issue_tag = '0; host_done = 0; card_done = 0; cpl_ready = 0;
      tq.delete(); m_h = 0; m_c = 0; m_valid = 0; m_tag = '0; m_err = 0;
      repeat (2) step();
      areset = 1'b0;
      chk("rst_rdy", 32'(issue_ready), 32'(1));
      chk("rst_vld", 32'(cpl_valid), 32'(0));
      chk("rst_tag", 32'(cpl_tag), 32'(0));
      chk("rst_out", 32'(outstanding), 32'(0));
      chk("rst_err", 32'(err_overrun), 32'(0));

      // Single request: host at t+3, card at t+7, completion visible at t+8.
      for (int k = 0; k <= 7; k++) begin
         drv(k == 0, 10'h2A5, k == 3, k == 7, 1);
         if (k == 0) chk("t1_out1", 32'(outstanding), 32'(1));
         if (k == 6) chk("t1_novld", 32'(cpl_valid), 32'(0));
      end
      chk("t1_vld", 32'(cpl_valid), 32'(1));
      chk("t1_tag", 32'(cpl_tag), 32'(10'h2A5));
      chk("t1_out0", 32'(outstanding), 32'(0));
      drv(0, '0, 0, 0, 1);
      chk("t1_done", 32'(cpl_valid), 32'(0));

      // Card side finishes first for three requests; host dones release them in order.
      for (int i = 1; i <= 3; i++) drv(1, TAG_W'(i), 0, 0, 1);
      for (int i = 1; i <= 3; i++) drv(0, '0, 0, 1, 1);
      chk("t2_wait", 32'(cpl_valid), 32'(0));
      for (int i = 1; i <= 3; i++) begin
         drv(0, '0, 1, 0, 1);
         chk("t2_vld", 32'(cpl_valid), 32'(1));
         chk("t2_ord", 32'(cpl_tag), 32'(i));
      end
      drv(0, '0, 0, 0, 1);
      chk("t2_end", 32'(cpl_valid), 32'(0));

      // Fill to DEPTH, then one retire reopens issue.
      for (int i = 0; i < DEPTH; i++) drv(1, TAG_W'($urandom), 0, 0, 1);
      drv(1, 10'h3FF, 0, 0, 1);
      chk("t3_full", 32'(issue_ready), 32'(0));
      chk("t3_out16", 32'(outstanding), 32'(DEPTH));
      drv(0, '0, 1, 1, 1);
      chk("t3_reopen", 32'(issue_ready), 32'(1));
      chk("t3_out15", 32'(outstanding), 32'(DEPTH - 1));
      drain();

      // Backpressure: completion must hold for 10 cycles, then both drain back-to-back.
      drv(1, 10'h0A1, 0, 0, 0);
      drv(1, 10'h0B2, 0, 0, 0);
      drv(0, '0, 1, 1, 0);
      drv(0, '0, 1, 1, 0);
      for (int i = 0; i < 10; i++) begin
         drv(0, '0, 0, 0, 0);
         chk("t4_hold", 32'(cpl_tag), 32'(10'h0A1));
      end
      drv(0, '0, 0, 0, 1);
      chk("t4_second", 32'(cpl_tag), 32'(10'h0B2));
      chk("t4_vld2", 32'(cpl_valid), 32'(1));
      drv(0, '0, 0, 0, 1);
      chk("t4_empty", 32'(cpl_valid), 32'(0));

      // Overrun: host done with nothing outstanding is dropped and flagged.
      drv(0, '0, 1, 0, 1);
      chk("t5_err", 32'(err_overrun), 32'(1));
      drv(1, 10'h055, 0, 1, 1);
      repeat (3) drv(0, '0, 0, 1, 1);
      chk("t5_nocpl", 32'(cpl_valid), 32'(0));
      drv(0, '0, 1, 0, 1);
      chk("t5_cpl", 32'(cpl_tag), 32'(10'h055));
      drv(0, '0, 0, 0, 1);

      // Reset mid-flight: 4 outstanding with 2 host halves counted.
      for (int i = 0; i < 4; i++) drv(1, TAG_W'(16 + i), 0, 0, 1);
      drv(0, '0, 1, 0, 1);
      drv(0, '0, 1, 0, 1);
      do_reset();
      chk("t6_rdy", 32'(issue_ready), 32'(1));
      chk("t6_vld", 32'(cpl_valid), 32'(0));
      chk("t6_tag", 32'(cpl_tag), 32'(0));
      chk("t6_out", 32'(outstanding), 32'(0));
      chk("t6_err", 32'(err_overrun), 32'(0));
      drv(1, 10'h001, 0, 0, 1);
      drv(0, '0, 1, 1, 1);
      chk("t6_cpl", 32'(cpl_tag), 32'(10'h001));
      chk("t6_cvld", 32'(cpl_valid), 32'(1));
      drv(0, '0, 0, 0, 1);

      // Random traffic with only legal dones.
      for (int i = 0; i < 800; i++) begin
         drv(($urandom % 2) == 0, TAG_W'($urandom),
             (($urandom % 3) == 0) && (m_h < tq.size()),
             (($urandom % 3) == 0) && (m_c < tq.size()),
             ($urandom % 4) != 0);
      end
      drain();

      // Random traffic where stray dones may occur.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drv(($urandom % 2) == 0, TAG_W'($urandom),
             ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 4) != 0);
      end
      drain();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/isr_cpl_join.md
# isr_cpl_join

Completion joiner for split ISR DMA transfers. Each ISR request is issued as a host half and a card half in parallel. This block records every issued request in order, collects the per-side `done` pulses, and emits exactly one in-order completion once both halves of the oldest request have finished. It sits between the TLB assign stage and the ISR completion/credit logic, and provides the return path that the split side lacks.

## Interface
- `DEPTH`, 16: max outstanding joined requests; power of two, 2–64.
- `TAG_W`, 10: completion tag width (pid 6b + dest 4b, packed by issuer).
- `aclk` in 1: clock.
- `areset` in 1: synchronous, active-high reset.
- `issue_valid` in 1: request issued to both sides this cycle.
- `issue_ready` out 1: tracker can accept an issue.
- `issue_tag` in TAG_W: tag carried back on completion.
- `host_done` in 1: single-cycle pulse, oldest host half finished (host completes in order).
- `card_done` in 1: single-cycle pulse, oldest card half finished (card completes in order).
- `cpl_valid` out 1: joined completion available.
- `cpl_ready` in 1: consumer accepts completion.
- `cpl_tag` out TAG_W: tag of completed request.
- `outstanding` out $clog2(DEPTH)+1: entries currently tracked.
- `err_overrun` out 1: sticky; a done arrived with no matching outstanding half.

## Operation
- Tag FIFO, DEPTH entries: write on `issue_valid & issue_ready`, read on retire.
- `issue_ready` = not full. There is no bypass when full, even if a retire happens in the same cycle.
- Per-side pending counters `host_cnt` and `card_cnt`, each $clog2(DEPTH)+1 bits, count completed-but-unretired halves.
- Each counter's next value = cnt + done − retire, evaluated in the same cycle. Simultaneous done and retire leave the counter unchanged.
- A done is legal only if cnt < outstanding. Otherwise the pulse is dropped, the counter is unchanged, and `err_overrun` sets. `err_overrun` clears only on reset.
- Output register FSM:
  - IDLE: `cpl_valid`=0. Go to HOLD when the FIFO is non-empty and `host_cnt`≥1 and `card_cnt`≥1. On that transition, pop the head into `cpl_tag`, and decrement both counters and `outstanding` (this is the retire).
  - HOLD: `cpl_valid`=1, `cpl_tag` stable. On `cpl_ready`, either retire the next ready head directly (stay in HOLD) or go to IDLE.
- Completions leave strictly in issue order, regardless of which side finished first.
- Reset mid-operation clears FIFO pointers, counters, FSM state and the error flag. Halves still in flight are forgotten; their later dones count as overrun.

## Timing
- Reset values: `issue_ready`=1, `cpl_valid`=0, `cpl_tag`=0, `outstanding`=0, `err_overrun`=0.
- Issue is visible in `outstanding` on the next cycle.
- Latency: the last done of the head at cycle N gives `cpl_valid`=1 at cycle N+1.
- Back-to-back: with `cpl_ready` held at 1 and all counters ready, throughput is one completion per cycle.
- `cpl_valid`/`cpl_tag` follow AXI-style hold: they may not drop or change until accepted.
- Full FIFO: `issue_ready`=0 on the cycle after the DEPTH-th issue. It returns to 1 on the cycle after a retire.

## Structure
- Package `lynxTypes` gains:
  - `ISR_CPL_TAG_BITS`=10;
  - typedef `isr_cpl_t` with pid[5:0] and dest[3:0];
  - localparam `ISR_CPL_DEPTH`=16.
- One sub-module, `isr_tag_fifo`: synchronous register FIFO providing full/empty/count.
- The join FSM and counters live in the top module.

## Test plan
- Single request, tag 0x2A5: host_done at t+3, card_done at t+7 → `cpl_valid` at t+8 with `cpl_tag`=0x2A5; `outstanding` goes 1→0 on acceptance.
- Tags 1,2,3 issued; card dones for all three first, then host dones → completions 1,2,3 in order, one per cycle with `cpl_ready`=1.
- DEPTH=16 issues with no dones → `issue_ready`=0 and `outstanding`=16. One host+card done then acceptance → `issue_ready`=1.
- `cpl_ready`=0 for 10 cycles with 2 completed requests → `cpl_tag` stable, then both drain back-to-back.
- host_done with `outstanding`=0 → `err_overrun`=1, `host_cnt` stays 0, and no completion is emitted.
- Reset asserted with 4 outstanding and 2 host dones counted → next cycle all outputs at reset values; a new tag 0x001 then completes normally.
